// File: rtl/press_counter_display.sv
// press_counter_display
// Counts debounced push-button presses as a 4-digit BCD total and scans that
// total onto a 4-digit, common-anode, multiplexed seven-segment display.
// The press pulse arrives from a slower debounce clock domain, so it is
// resynchronised and edge-detected before it advances the counter.
module press_counter_display #(
  parameter int SCAN_CYCLES = 50000,
  parameter int SCAN_W      = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_press,
  input  logic        i_clear,
  output logic [15:0] o_count,
  output logic        o_wrap,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic              s1_r;
  logic              s2_r;
  logic              s3_r;
  logic              inc_s;
  logic [15:0]       count_r;
  logic [15:0]       count_next_s;
  logic              wrap_r;
  logic              wrap_next_s;
  logic [16:0]       bcd_sum_s;
  logic [SCAN_W-1:0] scan_r;
  logic [1:0]        digit_r;
  logic [3:0]        nibble_s;

  // Adds one to a 4-digit BCD value; bit 16 of the result is the carry out
  // of the thousands digit, i.e. the 9999 -> 0000 rollover.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return {carry, r};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Two-flop resynchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= i_press;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign inc_s     = s2_r & ~s3_r;
  assign bcd_sum_s = bcd_inc(count_r);

  // Next count: clear beats increment, and an edge coinciding with clear is dropped.
  always_comb begin
    count_next_s = count_r;
    wrap_next_s  = 1'b0;
    if (i_clear) begin
      count_next_s = 16'h0000;
      wrap_next_s  = 1'b0;
    end else if (inc_s) begin
      count_next_s = bcd_sum_s[15:0];
      wrap_next_s  = bcd_sum_s[16];
    end else begin
      count_next_s = count_r;
      wrap_next_s  = 1'b0;
    end
  end

  // Count and rollover-pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= 16'h0000;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      wrap_r  <= wrap_next_s;
    end
  end

  // Free-running scan timer; each digit stays lit for SCAN_CYCLES cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan_r  <= {SCAN_W{1'b0}};
      digit_r <= 2'd0;
    end else if (scan_r == SCAN_LAST) begin
      scan_r  <= {SCAN_W{1'b0}};
      digit_r <= digit_r + 2'd1;
    end else begin
      scan_r  <= scan_r + {{(SCAN_W-1){1'b0}}, 1'b1};
      digit_r <= digit_r;
    end
  end

  // Select the nibble for the currently scanned digit.
  always_comb begin
    nibble_s = count_r[3:0];
    case (digit_r)
      2'd0:    nibble_s = count_r[3:0];
      2'd1:    nibble_s = count_r[7:4];
      2'd2:    nibble_s = count_r[11:8];
      2'd3:    nibble_s = count_r[15:12];
      default: nibble_s = count_r[3:0];
    endcase
  end

  // Display drive follows digit and count with no added latency.
  always_comb begin
    o_an  = ~(4'b0001 << digit_r);
    o_seg = seg_decode(nibble_s);
  end

  assign o_count = count_r;
  assign o_wrap  = wrap_r;

endmodule

// File: tb/tb_press_counter_display.sv
// Testbench for press_counter_display: a decimal reference count produces
// expected BCD values, queued when a press is driven and compared when the
// DUT count changes, including the cycle at which the change must appear.
module tb_press_counter_display;

  localparam int SCAN_CYCLES = 4;
  localparam int SCAN_W      = 3;

  logic        clk;
  logic        i_rst;
  logic        i_press;
  logic        i_clear;
  logic [15:0] o_count;
  logic        o_wrap;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;

  typedef struct {
    logic [15:0] cnt;
    logic        wrap;
    int          due;
  } sb_t;

  sb_t         sb_q[$];
  int          n_cmp;
  int          n_err;
  int          cyc;
  int          exp_dec;
  logic [15:0] prev_count;

  press_counter_display #(
    .SCAN_CYCLES(SCAN_CYCLES),
    .SCAN_W     (SCAN_W)
  ) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_press(i_press),
    .i_clear(i_clear),
    .o_count(o_count),
    .o_wrap (o_wrap),
    .o_an   (o_an),
    .o_seg  (o_seg)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to timestamp expected count changes.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Advance one edge; inputs are then changed just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press: queue the expected count, then pulse i_press for `hold` cycles.
  task automatic press(input int hold);
    sb_t e;
    exp_dec = (exp_dec + 1) % 10000;
    e.cnt   = to_bcd(exp_dec);
    e.wrap  = (exp_dec == 0);
    e.due   = cyc + 3;
    sb_q.push_back(e);
    i_press = 1'b1;
    repeat (hold) tick();
    i_press = 1'b0;
    repeat (2) tick();
  endtask

  // Monitor: every change of o_count must match the head of the scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (i_rst) begin
      prev_count = o_count;
    end else begin
      if (o_count !== prev_count) begin
        if (sb_q.size() == 0) begin
          check("unexpected_change", 32'(o_count), 32'(prev_count));
        end else begin
          e = sb_q.pop_front();
          check("count", 32'(o_count), 32'(e.cnt));
          check("wrap", 32'(o_wrap), 32'(e.wrap));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end else if (o_wrap !== 1'b0) begin
        check("spurious_wrap", 32'(o_wrap), 32'd0);
      end
      prev_count = o_count;
    end
  end

  logic [3:0] scan_an [4];
  logic [6:0] scan_seg[4];

  initial begin
    logic [3:0] prev_an;
    bit         synced;
    int         j;

    n_cmp   = 0;
    n_err   = 0;
    exp_dec = 0;
    i_rst   = 1'b1;
    i_press = 1'b0;
    i_clear = 1'b0;
    scan_an[0]  = 4'b1110; scan_seg[0] = 7'b0011001;
    scan_an[1]  = 4'b1101; scan_seg[1] = 7'b0110000;
    scan_an[2]  = 4'b1011; scan_seg[2] = 7'b0100100;
    scan_an[3]  = 4'b0111; scan_seg[3] = 7'b1111001;

    // Reset state.
    repeat (3) tick();
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(o_count), 32'h0000);
    check("rst_wrap", 32'(o_wrap), 32'd0);
    check("rst_an", 32'(o_an), 32'b1110);
    check("rst_seg", 32'(o_seg), 32'b1000000);

    // First digit change lands exactly SCAN_CYCLES edges after release.
    for (int i = 1; i <= SCAN_CYCLES; i++) begin
      tick();
      @(negedge clk);
      check("scan_first", 32'(o_an), (i < SCAN_CYCLES) ? 32'b1110 : 32'b1101);
    end
    tick();

    // Single long press counts once.
    press(20);
    check("single", 32'(o_count), 32'h0001);

    // Carries.
    repeat (9) press(2);
    check("carry_10", 32'(o_count), 32'h0010);
    repeat (99) press(2);
    check("carry_109", 32'(o_count), 32'h0109);
    repeat (1234 - 109) press(2);
    check("reach_1234", 32'(o_count), 32'h1234);

    // Scan sequence for 1234: align on the units digit, then check 4 x 4 cycles.
    repeat (4) tick();
    @(negedge clk);
    prev_an = o_an;
    synced  = 1'b0;
    for (int i = 0; i < 20 && !synced; i++) begin
      @(negedge clk);
      if (prev_an == 4'b0111 && o_an == 4'b1110) synced = 1'b1;
      else prev_an = o_an;
    end
    check("scan_sync", 32'(synced), 32'd1);
    if (synced) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < SCAN_CYCLES; c++) begin
          check("scan_an", 32'(o_an), 32'(scan_an[d]));
          check("scan_seg", 32'(o_seg), 32'(scan_seg[d]));
          if (!(d == 3 && c == SCAN_CYCLES - 1)) @(negedge clk);
        end
      end
    end
    tick();

    // Rollover.
    repeat (9999 - 1234) press(2);
    check("reach_9999", 32'(o_count), 32'h9999);
    press(2);
    check("rollover", 32'(o_count), 32'h0000);
    press(2);

    // Reset while a press is in flight, press still high after release.
    i_press = 1'b1;
    tick();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst   = 1'b0;
    exp_dec = 0;
    begin
      sb_t e;
      exp_dec = 1;
      e.cnt   = to_bcd(exp_dec);
      e.wrap  = 1'b0;
      e.due   = cyc + 3;
      sb_q.push_back(e);
    end
    repeat (6) tick();
    i_press = 1'b0;
    repeat (3) tick();
    check("after_mid_rst", 32'(o_count), 32'h0001);

    // Clear coinciding with the increment cycle: count goes to 0 and the press is dropped.
    begin
      sb_t e;
      exp_dec = 0;
      e.cnt   = 16'h0000;
      e.wrap  = 1'b0;
      e.due   = cyc + 3;
      sb_q.push_back(e);
    end
    i_press = 1'b1;
    tick();
    tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    j = 0;
    repeat (5) begin
      tick();
      j++;
    end
    i_press = 1'b0;
    repeat (6) tick();

    check("clear_final", 32'(o_count), 32'h0000);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/press_counter_display.md
# press_counter_display

Counts debounced push-button presses and shows the running total on a 4-digit, common-anode, multiplexed seven-segment display. It sits directly downstream of the switch debouncer and consumes its single-pulse output. That pulse is produced in the slow debounce clock domain and lasts one slow-clock period, so this block resynchronises it into `i_clk`, detects its rising edge, and advances a 4-digit BCD counter. A free-running scan counter drives the display digit by digit.

## Interface
Parameters:
- `SCAN_CYCLES`, default 50000: `i_clk` cycles each digit is lit. Legal range ≥ 2.
- `SCAN_W`, default 16: width of the scan counter. Must satisfy 2^SCAN_W ≥ SCAN_CYCLES.

Ports:
- `i_clk`, input, 1 bit: the single clock for the block. One clock; reset is synchronous and active-high.
- `i_rst`, input, 1 bit: synchronous, active-high reset, sampled on the `i_clk` rising edge.
- `i_press`, input, 1 bit: debounced press pulse from the debouncer. Asynchronous to `i_clk`; each high level is at least 2 `i_clk` cycles wide.
- `i_clear`, input, 1 bit: synchronous count clear. It is already in the `i_clk` domain.
- `o_count`, output, 16 bits: BCD count. `[15:12]` is thousands and `[3:0]` is units.
- `o_wrap`, output, 1 bit: one-cycle pulse when the count rolls over from 9999 to 0000.
- `o_an`, output, 4 bits: digit enables, active-low. `o_an[0]` is the units digit.
- `o_seg`, output, 7 bits: segments, active-low. Bit order is `{g,f,e,d,c,b,a}`, with `o_seg[0]` = a.

## Operation
- **Synchroniser:**
  - `i_press` → `s1` → `s2`, a 2-flop chain.
  - `s3` holds the previous value of `s2`.
  - `inc = s2 & ~s3`. One increment per rising edge regardless of how long `i_press` stays high.
- **Counter:** four BCD digits.
  - A digit that reaches 9 wraps to 0 and carries into the next digit.
  - 9999 + 1 → 0000, and `o_wrap` pulses.
  - No digit ever holds a value of 10–15.
- **Priority** (highest first):
  1. `i_rst`
  2. `i_clear`
  3. `inc`
- **`i_clear` behaviour:**
  - Forces the count to 0000. `o_wrap` stays 0.
  - The synchroniser chain keeps running.
  - An edge that coincides with `i_clear` is dropped, not deferred.
- **Scan counter:**
  - Counts 0 .. SCAN_CYCLES-1. At the terminal value it returns to 0 and `digit` advances 0→1→2→3→0.
  - `i_clear` does not affect the scan counter or `digit`.
- **Display decode:** combinational from registered `digit` and `o_count`.
  - `o_an = ~(4'b0001 << digit)`.
  - `o_seg` is the active-low decode of the selected nibble. Leading zeros are shown.
  - Nibble encodings: 0=`1000000`, 1=`1111001`, 2=`0100100`, 3=`0110000`, 4=`0011001`, 5=`0010010`, 6=`0000010`, 7=`1111000`, 8=`0000000`, 9=`0010000`. Any other value gives `1111111` (blank, unreachable).
- **Reset values:**
  - `s1`, `s2`, `s3` = 0.
  - `o_count` = 16'h0000, `o_wrap` = 0.
  - Scan counter = 0, `digit` = 0.
  - Therefore `o_an` = 4'b1110 and `o_seg` = 7'b1000000.

## Timing
- **Press latency:**
  - `i_press` first sampled high at edge N: `s1` = 1 after N, `s2` = 1 after N+1.
  - `inc` is high during the cycle between N+1 and N+2.
  - `o_count` holds the new value after edge N+2.
- **`o_wrap`:** registered. High for exactly the cycle following the edge at which `o_count` becomes 0000 by rollover.
- **Scan timing:**
  - Each digit is active for exactly SCAN_CYCLES cycles.
  - The first digit change after reset deassertion occurs SCAN_CYCLES edges later.
- **Display update:** `o_an` and `o_seg` change in the same cycle as `digit` or `o_count`, with zero added latency.
- **Reset mid-operation:**
  - Everything returns to the reset values at the next edge.
  - A press in flight in the synchroniser is lost.
  - If `i_press` is still high after reset releases, it produces one increment, because `s3` was cleared.
- **Back-to-back presses:** need `i_press` low for ≥ 2 cycles between them. That is guaranteed upstream.

## Test plan
- **Reset:** hold `i_rst` for 3 cycles, then release → `o_count` = 0000, `o_wrap` = 0, `o_an` = 1110, `o_seg` = 1000000.
- **Single press:** `i_press` high for 20 cycles starting at edge N → `o_count` = 0001 after edge N+2, with no further change. `inc` high for exactly 1 cycle.
- **Carry:** 10 presses → 0010. 99 more presses (109 total) → 0109. Check that no nibble ever exceeds 9.
- **Rollover:** preload by pressing to 9999 (or force in the test), then press once → `o_count` = 0000, `o_wrap` high for 1 cycle.
- **Clear:** raise `i_clear` in the same cycle `inc` is high → `o_count` = 0000 afterwards, and the press is not counted later.
- **Scan:** SCAN_CYCLES=4, count 1234 → `o_an` sequence 1110 / 1101 / 1011 / 0111, each held 4 cycles. `o_seg` sequence 0011001 / 0110000 / 0100100 / 1111001.
